// File: rtl/scan_display_driver_pkg.sv
// Shared constants, segment decoding and FSM state type for the multiplexed
// 7-segment display driver.
package scan_display_driver_pkg;

  // Segment codes, active-high, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } state_t;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Decimal digits of 2^width-1, i.e. ceil(width*log10(2)); never an exact integer
  function automatic int bcd_nibbles(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/scan_display_driver_if.sv
// Value handshake between the ALU result register and the display driver.
interface scan_display_driver_if #(parameter int WIDTH = 16);
  // A value transfers on a rising edge where value_valid && value_ready;
  // value_valid while value_ready is low is dropped, never queued.
  logic [WIDTH-1:0] value;
  logic             value_valid;
  logic             value_ready;

  modport master (output value, output value_valid, input value_ready);
  modport slave  (input value, input value_valid, output value_ready);
endinterface

// File: rtl/scan_display_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock after start.
module bin2bcd_seq
  import scan_display_driver_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIB   = bcd_nibbles(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [4*NIB-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] bin_q;
  logic [4*NIB-1:0] bcd_q;
  logic [4*NIB-1:0] bcd_adj;
  logic [CW-1:0]    cnt_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NIB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bin_q <= bin;
        bcd_q <= '0;
        cnt_q <= CW'(WIDTH);
        busy  <= 1'b1;
      end else if (busy) begin
        {bcd_q, bin_q} <= {bcd_adj[4*NIB-2:0], bin_q, 1'b0};
        cnt_q          <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/scan_display_driver.sv
// Multiplexed 7-segment driver: accepts a binary value, converts to BCD,
// formats sign/blanking/overflow and scans DIGITS indicators.
module scan_display_driver
  import scan_display_driver_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit SIGNED     = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  scan_display_driver_if.slave  bus,
  output logic [7:0]            indicator,
  output logic [DIGITS-1:0]     indicator_choice,
  output logic                  overflow,
  output state_t                dbg_state
);

  localparam int NIB  = bcd_nibbles(WIDTH);
  localparam int MAXN = (NIB > DIGITS) ? NIB : DIGITS;
  localparam int IW   = $clog2(DIGITS);
  localparam int PW   = $clog2(SCAN_DIV);

  state_t state_q, state_d;
  logic start, commit, conv_busy, conv_done;
  logic [4*NIB-1:0] bcd;
  logic             value_neg, neg_q;
  logic [WIDTH-1:0] value_mag;

  assign value_neg = SIGNED && bus.value[WIDTH-1];
  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude
  assign value_mag = value_neg ? ((~bus.value) + WIDTH'(1)) : bus.value;
  assign bus.value_ready = (state_q == ST_IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.value_valid) begin
          start   = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (conv_done)      state_d = ST_COMMIT;
        else if (!conv_busy) state_d = ST_IDLE;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) neg_q <= value_neg;
    end
  end

  bin2bcd_seq #(.WIDTH(WIDTH), .NIB(NIB)) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (value_mag),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Formatter: next display contents from the finished conversion
  logic [4*MAXN-1:0] bcd_pad;
  logic [7:0]        disp_d [DIGITS];
  logic [7:0]        disp_q [DIGITS];
  logic              ovf_d;
  int                msd;

  always_comb begin
    bcd_pad = '0;
    bcd_pad[4*NIB-1:0] = bcd;
    msd = 0;
    for (int i = 0; i < MAXN; i++) begin
      if (bcd_pad[4*i +: 4] != 4'd0) msd = i;
    end
    ovf_d = (msd >= DIGITS) || (neg_q && (msd + 1 >= DIGITS));
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_d)                     disp_d[i] = SEG_MINUS;
      else if (i <= msd)             disp_d[i] = bcd_to_seg(bcd_pad[4*i +: 4]);
      else if (neg_q && i == msd + 1) disp_d[i] = SEG_MINUS;
      else                           disp_d[i] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= SEG_BLANK;
      overflow <= 1'b0;
    end else if (commit) begin
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= disp_d[i];
      overflow <= ovf_d;
    end
  end

  // Scanner: prescaler and digit index, outputs registered together
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          wrap;
  logic [7:0]    seg_sel;
  logic [DIGITS-1:0] onehot;

  always_comb begin
    wrap    = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = wrap ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (wrap) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    // A commit on the same edge must show the new contents immediately
    seg_sel = commit ? disp_d[idx_d] : disp_q[idx_d];
    onehot  = DIGITS'(1) << idx_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q          <= '0;
      idx_q            <= '0;
      indicator        <= {8{ACTIVE_LOW}};
      indicator_choice <= {DIGITS{ACTIVE_LOW}};
    end else begin
      presc_q          <= presc_d;
      idx_q            <= idx_d;
      indicator        <= ACTIVE_LOW ? ~seg_sel : seg_sel;
      indicator_choice <= ACTIVE_LOW ? ~onehot : onehot;
    end
  end

endmodule

// File: tb/tb_scan_display_driver.sv
// Randomized scoreboard bench for scan_display_driver against a decimal
// arithmetic reference model of the expected display frame.
module tb_scan_display_driver;
  import scan_display_driver_pkg::*;

  localparam int WIDTH    = 16;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FW       = 8 * DIGITS + 1;

  // Clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]        indicator;
  logic [DIGITS-1:0] indicator_choice;
  logic              overflow;
  state_t            dbg_state;

  scan_display_driver_if #(.WIDTH(WIDTH)) bus ();

  scan_display_driver #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SIGNED(1'b1), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .indicator        (indicator),
    .indicator_choice (indicator_choice),
    .overflow         (overflow),
    .dbg_state        (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int k = 0;
  logic [FW-1:0] exp_q[$];

  // Edges since reset release: digit shown is (k / SCAN_DIV) % DIGITS
  always @(posedge clk or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] ref_seg(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
      4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
      8: return 8'h7F; default: return 8'h6F;
    endcase
  endfunction

  // Frame = {overflow, digit3 .. digit0} as active-low pin values
  function automatic logic [FW-1:0] model(input logic [WIDTH-1:0] v);
    logic [FW-1:0] f;
    logic [7:0] seg;
    int s, mag, n;
    bit neg, ovf;
    int d[$];
    s   = v[WIDTH-1] ? int'(v) - (1 << WIDTH) : int'(v);
    neg = (s < 0);
    mag = neg ? -s : s;
    do begin
      d.push_back(mag % 10);
      mag = mag / 10;
    end while (mag > 0);
    n   = d.size();
    ovf = (n + int'(neg)) > DIGITS;
    f = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf)                 seg = 8'h40;
      else if (i < n)          seg = ref_seg(d[i]);
      else if (neg && i == n)  seg = 8'h40;
      else                     seg = 8'h00;
      f[8*i +: 8] = ~seg;
    end
    f[FW-1] = ovf;
    return f;
  endfunction

  // Monitor: a commit is the return of value_ready; then one full scan is checked
  int low_cnt = 0;
  int chk_left = 0;
  logic [FW-1:0] cur = '0;

  always @(negedge clk) begin
    int idx;
    logic [DIGITS-1:0] exp_ch;
    if (!reset) begin
      low_cnt  = 0;
      chk_left = 0;
    end else begin
      if (!bus.value_ready) low_cnt++;
      else if (low_cnt > 0) begin
        check("ready_low_cycles", low_cnt, WIDTH + 2);
        low_cnt = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_commit: got commit expected none (t=%0t)", $time);
        end else begin
          cur      = exp_q.pop_front();
          chk_left = DIGITS * SCAN_DIV;
        end
      end
      if (chk_left > 0) begin
        idx    = (k / SCAN_DIV) % DIGITS;
        exp_ch = ~(DIGITS'(1) << idx);
        check("choice", indicator_choice, exp_ch);
        check("indicator", indicator, cur[8*idx +: 8]);
        check("overflow", overflow, cur[FW-1]);
        chk_left--;
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [WIDTH-1:0] v);
    int n = 0;
    while (!bus.value_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!bus.value_ready) begin
      errors++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1");
      return;
    end
    bus.value       = v;
    bus.value_valid = 1'b1;
    exp_q.push_back(model(v));
    @(posedge clk); #1;
    bus.value_valid = 1'b0;
    bus.value       = WIDTH'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || chk_left > 0) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", (exp_q.size() > 0 || chk_left > 0), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_indicator"}, indicator, 8'hFF);
    check({tag, "_choice"}, indicator_choice, {DIGITS{1'b1}});
    check({tag, "_ready"}, bus.value_ready, 1'b1);
    check({tag, "_overflow"}, overflow, 1'b0);
  endtask

  logic [WIDTH-1:0] directed [12] = '{16'd1234, 16'd7, 16'd0, 16'hFFD6, 16'd12345, 16'd5,
                                      16'h8000, 16'd9999, 16'hFC19, 16'hFC18, 16'hFFFF, 16'd32767};

  initial begin
    bus.value       = '0;
    bus.value_valid = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #3 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    foreach (directed[i]) begin
      send(directed[i]);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #0;
    end

    // Valid while converting must be ignored
    send(16'd321);
    repeat (4) @(posedge clk);
    bus.value       = 16'd999;
    bus.value_valid = 1'b1;
    @(posedge clk); #1;
    bus.value_valid = 1'b0;
    drain();

    for (int i = 0; i < 25; i++) begin
      send(WIDTH'($urandom_range(0, 65535)));
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    drain();

    // Reset in the middle of a scan
    repeat (6) @(posedge clk);
    #3 reset = 1'b0;
    #1 check_reset_outputs("midscan");
    @(posedge clk); #2 reset = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("blank_after_reset", indicator, 8'hFF);

    // Reset during conversion discards it
    send(16'd1111);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs("convert");
    @(posedge clk); #2 reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("no_commit_indicator", indicator, 8'hFF);
      check("no_commit_ready", bus.value_ready, 1'b1);
    end

    send(16'd5);
    send(16'hFFF6);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
